life_display_sequencer: RTL and testbench
=========================================

Name: life_display_sequencer

Overview:
- Sequenced controller for the game-of-life pixel renderer. It owns the displayed 256-cell map and the live-cell circle radius that feed the renderer.
- Commits a new generation only at frame boundaries. Visual order: shrink circles, swap map, grow circles.
- Arbitrates between generation-step requests and cursor-edit toggles.
- Sits between the life-update engine, the cursor/edit input logic, the VGA sync generator and the renderer.

Parameters:
- MAX_RADIUS, 8, live-cell circle radius at rest; also the grow target.
- MIN_RADIUS, 2, shrink target; must be < MAX_RADIUS.
- FRAMES_PER_STEP, 2, frame_start pulses per 1-unit radius change; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank, from the sync generator.
- step_req  in  1  level request: a new generation is on next_map.
- next_map  in  256  next generation; bit index = y*16+x.
- step_ack  out  1  one-cycle pulse when the step sequence completes.
- edit_req  in  1  one-cycle pulse: toggle the cell under the cursor.
- x_cursor  in  4  cursor column, sampled on edit_req.
- y_cursor  in  4  cursor row, sampled on edit_req.
- edit_ack  out  1  one-cycle pulse when the toggle is applied.
- map_out  out  256  displayed map, to the renderer.
- radius  out  5  live-cell circle radius, to the renderer.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: map_out=0, radius=MAX_RADIUS, state=IDLE, step_ack=0, edit_ack=0, busy=0, edit_pending=0, frame_cnt=0.
- Reset mid-sequence aborts immediately. Any captured next_map and any pending edit are discarded.
- All outputs are registered. Every map_out or radius change occurs on the clk edge that samples frame_start=1, so the renderer never sees a change mid-frame.

State machine:
- IDLE: if step_req=1, capture next_map into shadow_map and go to SHRINK. The capture edge does not need frame_start.
- SHRINK: count frame_start pulses in frame_cnt. When frame_cnt reaches FRAMES_PER_STEP-1 on a frame_start, decrement radius and clear frame_cnt. When radius becomes MIN_RADIUS, go to SWAP.
- SWAP: on the next frame_start, map_out <= shadow_map; go to GROW.
- GROW: same counting as SHRINK, but radius increments. On the edge where radius becomes MAX_RADIUS, pulse step_ack and go to IDLE.
- frame_cnt clears on every state entry.

Step handshake:
- step_req is ignored outside IDLE.
- next_map may change freely after the capture edge.
- The requester deasserts step_req the cycle after step_ack; a still-high step_req in IDLE starts a new step.

Edits:
- edit_req captures (y_cursor*16 + x_cursor) into an 8-bit edit_pos and sets edit_pending. This happens in any state.
- A new edit_req while edit_pending=1 is dropped: no ack, position unchanged.
- A pending edit is applied on a frame_start edge while state=IDLE: toggle map_out[edit_pos], pulse edit_ack, clear edit_pending.
- The edit is never applied while busy.
- Simultaneous events:
  - Edit applied and step_req in the same IDLE edge: the edit toggles map_out, and the step also captures next_map. The later swap overwrites the edit, by design.
  - edit_req and edit apply in the same cycle: the new request is dropped.

Arithmetic:
- radius arithmetic is 5-bit unsigned; it never leaves [MIN_RADIUS, MAX_RADIUS].
- frame_cnt is $clog2(FRAMES_PER_STEP+1) bits wide.

Optional Feature:
- Macro: PULSE_ANIM_EN.
- Defined: full SHRINK/SWAP/GROW animation as above.
- Undefined:
  - radius is held constant at MAX_RADIUS.
  - The step path goes IDLE -> SWAP. On the first frame_start, map_out loads, step_ack pulses and the state returns to IDLE.
  - SHRINK/GROW logic and frame_cnt are not synthesised.

Decomposition:
- Package life_pkg:
  - GRID_DIM=16, MAP_BITS=256.
  - state enum {IDLE, SHRINK, SWAP, GROW}.
  - cell_index function (x,y -> y*16+x).
- One natural sub-module, life_frame_ticker: counts frame_start pulses and emits a tick every FRAMES_PER_STEP pulses, with a synchronous clear on state entry.

Test Plan:
- Defaults: rst for 2 cycles -> map_out=0, radius=8, busy=0, no acks.
- Step with animation (defaults, next_map=bit0 and bit255 set):
  - radius decrements on frame_starts 2, 4, ..., 12, reaching 2.
  - map_out updates at frame_start 13.
  - radius reaches 8 at frame_start 25, with one step_ack in that cycle.
  - map_out is never changed except on a frame_start edge.
- Edit in IDLE: edit_req with x=3, y=5 -> bit 83 toggles at the next frame_start with one edit_ack. Repeating the edit restores bit 83 to 0.
- Edit while busy: edit_req during SHRINK -> no change until IDLE. A second edit_req while pending is dropped. The first edit applies at the first frame_start after step_ack; exactly one edit_ack.
- Reset mid-SHRINK at radius=5 -> radius=8, map_out=0, pending edit gone, state IDLE.
- PULSE_ANIM_EN undefined, step_req -> radius stays 8; map_out loads at the first frame_start with step_ack in the same cycle.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and helpers for the life display sequencer.
// PULSE_ANIM_EN selects the animated step sequence in the top level.
package life_pkg;

    localparam int unsigned GRID_DIM = 16;
    localparam int unsigned MAP_BITS = 256;
    localparam int unsigned POS_W    = 8;
    localparam int unsigned RADIUS_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHRINK = 2'd1,
        ST_SWAP   = 2'd2,
        ST_GROW   = 2'd3
    } state_t;

    // Flat map bit index for a grid cell: y*16 + x.
    function automatic logic [POS_W-1:0] cell_index(input logic [3:0] x, input logic [3:0] y);
        return POS_W'(POS_W'(y) * POS_W'(GRID_DIM)) + POS_W'(x);
    endfunction

endpackage

// File: rtl/life_frame_ticker.sv
// Counts frame_start pulses while enabled; ticks every FRAMES_PER_STEP pulses.
// Only instantiated when PULSE_ANIM_EN is defined.
module life_frame_ticker #(
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_frame_start,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = $clog2(FRAMES_PER_STEP + 1);

    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_last;

    assign w_last   = (r_frame_cnt == CNT_W'(FRAMES_PER_STEP - 1));
    assign o_tick_c = i_en & i_frame_start & w_last;

    // Clear wins over counting so every state entry starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_frame_cnt <= '0;
        end else if (i_en && i_frame_start) begin
            r_frame_cnt <= w_last ? '0 : r_frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/life_display_sequencer.sv
// Owns the displayed life map and circle radius; commits steps and edits on frame boundaries.
// Define PULSE_ANIM_EN for the shrink/swap/grow animation; otherwise steps swap directly.
module life_display_sequencer
    import life_pkg::*;
#(
    parameter int unsigned MAX_RADIUS      = 8,
    parameter int unsigned MIN_RADIUS      = 2,
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_frame_start,
    input  logic                i_step_req,
    input  logic [MAP_BITS-1:0] i_next_map,
    output logic                o_step_ack,
    input  logic                i_edit_req,
    input  logic [3:0]          i_x_cursor,
    input  logic [3:0]          i_y_cursor,
    output logic                o_edit_ack,
    output logic [MAP_BITS-1:0] o_map_out,
    output logic [RADIUS_W-1:0] o_radius,
    output logic                o_busy
);

    state_t              r_state;
    logic                r_busy;
    logic [MAP_BITS-1:0] r_map;
    logic [MAP_BITS-1:0] r_shadow;
    logic                r_step_ack;
    logic                r_edit_ack;
    logic                r_edit_pending;
    logic [POS_W-1:0]    r_edit_pos;
    logic                w_edit_apply;

    assign o_map_out  = r_map;
    assign o_step_ack = r_step_ack;
    assign o_edit_ack = r_edit_ack;
    assign o_busy     = r_busy;

    assign w_edit_apply = r_edit_pending && (r_state == ST_IDLE) && i_frame_start;

`ifdef PULSE_ANIM_EN
    logic [RADIUS_W-1:0] r_radius;
    logic                w_tick;
    logic                w_en;
    logic                w_clr;

    assign o_radius = r_radius;
    assign w_en     = (r_state == ST_SHRINK) || (r_state == ST_GROW);

    // Frame counter restarts on every state transition.
    always_comb begin
        w_clr = 1'b0;
        case (r_state)
            ST_IDLE:   w_clr = i_step_req;
            ST_SHRINK: w_clr = w_tick && (r_radius == RADIUS_W'(MIN_RADIUS + 1));
            ST_SWAP:   w_clr = i_frame_start;
            ST_GROW:   w_clr = w_tick && (r_radius == RADIUS_W'(MAX_RADIUS - 1));
            default:   w_clr = 1'b0;
        endcase
    end

    life_frame_ticker #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_ticker (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (w_en),
        .i_clr         (w_clr),
        .i_frame_start (i_frame_start),
        .o_tick_c      (w_tick)
    );
`else
    logic w_unused_params;

    assign o_radius        = RADIUS_W'(MAX_RADIUS);
    assign w_unused_params = ^{RADIUS_W'(MIN_RADIUS), RADIUS_W'(FRAMES_PER_STEP)};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_map          <= '0;
            r_shadow       <= '0;
            r_step_ack     <= 1'b0;
            r_edit_ack     <= 1'b0;
            r_edit_pending <= 1'b0;
            r_edit_pos     <= '0;
`ifdef PULSE_ANIM_EN
            r_radius       <= RADIUS_W'(MAX_RADIUS);
`endif
        end else begin
            r_step_ack <= 1'b0;
            r_edit_ack <= 1'b0;

            // A request arriving while one is pending (or being applied) is dropped.
            if (w_edit_apply) begin
                r_map[r_edit_pos] <= ~r_map[r_edit_pos];
                r_edit_ack        <= 1'b1;
                r_edit_pending    <= 1'b0;
            end else if (i_edit_req && !r_edit_pending) begin
                r_edit_pos     <= cell_index(i_x_cursor, i_y_cursor);
                r_edit_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_step_req) begin
                        r_shadow <= i_next_map;
                        r_busy   <= 1'b1;
`ifdef PULSE_ANIM_EN
                        r_state  <= ST_SHRINK;
`else
                        r_state  <= ST_SWAP;
`endif
                    end
                end
`ifdef PULSE_ANIM_EN
                ST_SHRINK: begin
                    if (w_tick) begin
                        r_radius <= r_radius - RADIUS_W'(1);
                        if (r_radius == RADIUS_W'(MIN_RADIUS + 1)) begin
                            r_state <= ST_SWAP;
                        end
                    end
                end
                ST_SWAP: begin
                    if (i_frame_start) begin
                        r_map   <= r_shadow;
                        r_state <= ST_GROW;
                    end
                end
                ST_GROW: begin
                    if (w_tick) begin
                        r_radius <= r_radius + RADIUS_W'(1);
                        if (r_radius == RADIUS_W'(MAX_RADIUS - 1)) begin
                            r_step_ack <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
`else
                ST_SWAP: begin
                    if (i_frame_start) begin
                        r_map      <= r_shadow;
                        r_step_ack <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_display_sequencer.sv
// Directed bench for life_display_sequencer; follows PULSE_ANIM_EN to pick the expected step sequence.
module tb_life_display_sequencer;

    logic         i_clk;
    logic         i_rst;
    logic         i_frame_start;
    logic         i_step_req;
    logic [255:0] i_next_map;
    logic         o_step_ack;
    logic         i_edit_req;
    logic [3:0]   i_x_cursor;
    logic [3:0]   i_y_cursor;
    logic         o_edit_ack;
    logic [255:0] o_map_out;
    logic [4:0]   o_radius;
    logic         o_busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [255:0] m1, m2, m3, b83;

    life_display_sequencer dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_step_req    (i_step_req),
        .i_next_map    (i_next_map),
        .o_step_ack    (o_step_ack),
        .i_edit_req    (i_edit_req),
        .i_x_cursor    (i_x_cursor),
        .i_y_cursor    (i_y_cursor),
        .o_edit_ack    (o_edit_ack),
        .o_map_out     (o_map_out),
        .o_radius      (o_radius),
        .o_busy        (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic frame();
        i_frame_start = 1'b1;
        cycle();
        i_frame_start = 1'b0;
    endtask

    task automatic edit(input logic [3:0] x, input logic [3:0] y);
        i_edit_req = 1'b1;
        i_x_cursor = x;
        i_y_cursor = y;
        cycle();
        i_edit_req = 1'b0;
    endtask

    // Radius after f frame_starts of an animated step (defaults 8/2/2).
    function automatic int exp_rad(input int f);
        if (f <= 12) return 8 - f / 2;
        if (f == 13) return 2;
        return 2 + (f - 13) / 2;
    endfunction

    // Runs the 25 frames of an animated step; optionally posts two edits while busy.
    task automatic run_anim(input logic [255:0] m_old, input logic [255:0] m_new, input bit with_edits);
        for (int f = 1; f <= 25; f++) begin
            cycle();
            check("hold_map", o_map_out, (f - 1 >= 13) ? m_new : m_old);
            check("hold_radius", 256'(o_radius), 256'(exp_rad(f - 1)));
            if (with_edits && f == 2) edit(4'd3, 4'd5);
            if (with_edits && f == 3) edit(4'd0, 4'd0);
            frame();
            check("anim_map", o_map_out, (f >= 13) ? m_new : m_old);
            check("anim_radius", 256'(o_radius), 256'(exp_rad(f)));
            check("anim_step_ack", 256'(o_step_ack), 256'(f == 25));
            check("anim_edit_ack", 256'(o_edit_ack), 256'(0));
            check("anim_busy", 256'(o_busy), 256'(f != 25));
            if (f == 25) i_step_req = 1'b0;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_frame_start = 1'b0; i_step_req = 1'b0; i_next_map = '0;
        i_edit_req = 1'b0; i_x_cursor = '0; i_y_cursor = '0;
        m1 = '0; m1[0] = 1'b1; m1[255] = 1'b1;
        m2 = '0; m2[17] = 1'b1;
        m3 = 256'hF;
        b83 = '0; b83[83] = 1'b1;

        // Reset
        cycle(); cycle();
        check("rst_map", o_map_out, '0);
        check("rst_radius", 256'(o_radius), 256'(8));
        check("rst_busy", 256'(o_busy), 256'(0));
        check("rst_step_ack", 256'(o_step_ack), 256'(0));
        check("rst_edit_ack", 256'(o_edit_ack), 256'(0));
        i_rst = 1'b0;
        cycle();

        // Edit in IDLE toggles bit 83 only on frame_start, then toggles back
        edit(4'd3, 4'd5);
        check("edit_wait_map", o_map_out, '0);
        check("edit_wait_ack", 256'(o_edit_ack), 256'(0));
        frame();
        check("edit_map", o_map_out, b83);
        check("edit_ack", 256'(o_edit_ack), 256'(1));
        cycle();
        check("edit_ack_clr", 256'(o_edit_ack), 256'(0));
        edit(4'd3, 4'd5);
        frame();
        check("edit2_map", o_map_out, '0);
        check("edit2_ack", 256'(o_edit_ack), 256'(1));
        cycle();

`ifdef PULSE_ANIM_EN
        // Animated step with bit0/bit255
        i_next_map = m1; i_step_req = 1'b1;
        cycle();
        check("cap_busy", 256'(o_busy), 256'(1));
        check("cap_map", o_map_out, '0);
        i_next_map = ~m1;
        run_anim('0, m1, 1'b0);

        // Step with edits posted while busy; first edit applies after step_ack
        i_next_map = m2; i_step_req = 1'b1;
        cycle();
        i_next_map = '0;
        run_anim(m1, m2, 1'b1);
        frame();
        check("busy_edit_map", o_map_out, m2 ^ b83);
        check("busy_edit_ack", 256'(o_edit_ack), 256'(1));
        frame();
        check("dropped_edit_ack", 256'(o_edit_ack), 256'(0));
        check("dropped_edit_map", o_map_out, m2 ^ b83);

        // Reset mid-SHRINK at radius 5 with a pending edit
        i_next_map = m3; i_step_req = 1'b1;
        cycle();
        edit(4'd3, 4'd5);
        for (int f = 0; f < 6; f++) frame();
        check("mid_radius", 256'(o_radius), 256'(5));
        check("mid_busy", 256'(o_busy), 256'(1));
`else
        // Direct step: radius fixed, map loads on first frame_start with step_ack
        i_next_map = m1; i_step_req = 1'b1;
        cycle();
        check("cap_busy", 256'(o_busy), 256'(1));
        check("cap_map", o_map_out, '0);
        check("cap_radius", 256'(o_radius), 256'(8));
        i_next_map = ~m1;
        cycle();
        check("hold_map", o_map_out, '0);
        frame();
        check("swap_map", o_map_out, m1);
        check("swap_step_ack", 256'(o_step_ack), 256'(1));
        check("swap_busy", 256'(o_busy), 256'(0));
        check("swap_radius", 256'(o_radius), 256'(8));
        i_step_req = 1'b0;
        cycle();
        check("step_ack_clr", 256'(o_step_ack), 256'(0));
        check("idle_busy", 256'(o_busy), 256'(0));

        // Edits while busy: first waits for IDLE, second dropped
        i_next_map = m2; i_step_req = 1'b1;
        cycle();
        edit(4'd3, 4'd5);
        edit(4'd0, 4'd0);
        frame();
        check("busy_swap_map", o_map_out, m2);
        check("busy_step_ack", 256'(o_step_ack), 256'(1));
        check("busy_no_edit_ack", 256'(o_edit_ack), 256'(0));
        i_step_req = 1'b0;
        frame();
        check("busy_edit_map", o_map_out, m2 ^ b83);
        check("busy_edit_ack", 256'(o_edit_ack), 256'(1));
        frame();
        check("dropped_edit_ack", 256'(o_edit_ack), 256'(0));
        check("dropped_edit_map", o_map_out, m2 ^ b83);

        // Reset mid-sequence with a pending edit
        i_next_map = m3; i_step_req = 1'b1;
        cycle();
        edit(4'd3, 4'd5);
        check("mid_busy", 256'(o_busy), 256'(1));
`endif
        i_step_req = 1'b0;
        i_rst = 1'b1;
        cycle();
        check("mrst_radius", 256'(o_radius), 256'(8));
        check("mrst_map", o_map_out, '0);
        check("mrst_busy", 256'(o_busy), 256'(0));
        i_rst = 1'b0;
        frame();
        check("mrst_no_edit_ack", 256'(o_edit_ack), 256'(0));
        check("mrst_no_edit_map", o_map_out, '0);
        check("mrst_idle", 256'(o_busy), 256'(0));
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
